// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - instruction memory and decoder handshake bundle for inst_fetch
//
// Purpose: groups the two handshakes owned by the fetch stage.
//   Instruction memory side (req/ack):
//     imem_req    fetch -> memory  read request
//     imem_addr   fetch -> memory  byte address of the requested word
//     imem_ack    memory -> fetch  response strobe, imem_rdata valid same cycle
//     imem_rdata  memory -> fetch  returned instruction word
//   Decoder side (valid/ready):
//     inst        fetch -> decoder instruction register
//     inst_pc     fetch -> decoder address of the word held in inst
//     inst_valid  fetch -> decoder inst/inst_pc hold an undelivered instruction
//     inst_ready  decoder -> fetch decoder accepts inst this cycle
// Modports: master = fetch stage, slave = memory/decoder environment.

interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output inst,
    output inst_pc,
    output inst_valid,
    input  inst_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  inst,
    input  inst_pc,
    input  inst_valid,
    output inst_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: PC, imem req/ack, instruction register
//
// Purpose: owns the PC, issues one word read at a time to instruction memory,
// latches the returned word and hands it to the decoder. Redirects from the
// execute stage reload the PC and discard any fetch still in flight.
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   en           run enable; low only prevents starting a new fetch
//   bus          inst_fetch_if.master (imem req/addr/ack/rdata, inst/inst_pc/inst_valid/inst_ready)
//   redirect     one-cycle pulse, load PC from redirect_pc
//   redirect_pc  branch/jump target
//   align_err    sticky: a misaligned redirect target was seen
//   fetch_count  number of instructions delivered (valid && ready), wraps

module inst_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  inst_fetch_if.master        bus,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  output logic                align_err,
  output logic [31:0]         fetch_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  // Low bits forced to zero so imem_addr stays word aligned whatever the
  // parameter is set to.
  localparam logic [31:0] PC_INIT = {PC_RESET[31:2], 2'b00};

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic        pend;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        inst_valid_q;

  logic [31:0] target;
  logic [1:0]  resume_state;
  logic        deliver;

  assign target       = {redirect_pc[31:2], 2'b00};
  // After a fetch is finished or abandoned, only start another if enabled.
  assign resume_state = en ? REQ : IDLE;
  assign deliver      = inst_valid_q && bus.inst_ready;

  assign bus.imem_req   = (state == REQ);
  assign bus.imem_addr  = pc;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = inst_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= PC_INIT;
      pend         <= 1'b0;
      pend_pc      <= 32'h0;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
      inst_valid_q <= 1'b0;
      align_err    <= 1'b0;
      fetch_count  <= 32'h0;
    end else begin
      if (redirect && (redirect_pc[1:0] != 2'b00)) begin
        align_err <= 1'b1;
      end

      // A held instruction accepted in the same cycle as a redirect still
      // counts; only the next PC is affected by the redirect.
      if (deliver) begin
        fetch_count <= fetch_count + 32'd1;
      end

      case (state)
        IDLE: begin
          if (redirect) begin
            pc <= target;
          end
          if (en) begin
            state <= REQ;
          end
        end

        REQ: begin
          if (bus.imem_ack) begin
            if (redirect) begin
              // Redirect coincides with the response: drop the word, and this
              // newest target also supersedes any pending one.
              pc    <= target;
              pend  <= 1'b0;
              state <= resume_state;
            end else if (pend) begin
              // Response belongs to a fetch already made stale by a redirect.
              pc    <= pend_pc;
              pend  <= 1'b0;
              state <= resume_state;
            end else begin
              inst_q       <= bus.imem_rdata;
              inst_pc_q    <= pc;
              inst_valid_q <= 1'b1;
              pc           <= pc + 32'd4;
              state        <= HOLD;
            end
          end else if (redirect) begin
            // The memory handshake cannot be aborted: keep imem_req/imem_addr
            // up and remember where to go once the ack arrives. A later
            // redirect simply overwrites the stored target.
            pend    <= 1'b1;
            pend_pc <= target;
          end
        end

        HOLD: begin
          if (redirect || bus.inst_ready) begin
            inst_valid_q <= 1'b0;
            if (redirect) begin
              pc <= target;
            end
            state <= resume_state;
          end
        end

        default: begin
          state        <= IDLE;
          pend         <= 1'b0;
          inst_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch

module tb_inst_fetch;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_addr;
    logic        exp_align;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        align_err;
  logic [31:0] fetch_count;

  inst_fetch_if bus ();

  inst_fetch #(.PC_RESET(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bus        (bus),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .align_err  (align_err),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  exp_t        sb[$];
  logic [31:0] ack_addrs[$];
  vec_t        vecs[5];

  logic mem_on   = 1'b0;
  int   mem_delay = 0;
  logic late_ack = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s timeout", name);
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_edge();
    rst = 1'b1;
    drive_edge();
    rst = 1'b0;
  endtask

  // Memory model: acks after mem_delay cycles of continuous request.
  initial begin
    int wcnt;
    wcnt = 0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (late_ack) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        wcnt = 0;
      end else if (mem_on && bus.imem_req) begin
        if (wcnt >= mem_delay) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem_word(bus.imem_addr);
          wcnt = 0;
        end else begin
          bus.imem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        bus.imem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Delivery monitor: every valid&&ready must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.inst_valid && bus.inst_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_delivery inst=%h inst_pc=%h", bus.inst, bus.inst_pc);
        end else begin
          e = sb.pop_front();
          check("deliver_inst", bus.inst, e.inst);
          check("deliver_pc", bus.inst_pc, e.pc);
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.inst = mem_word(a);
    e.pc   = a;
    sb.push_back(e);
  endtask

  // Runs until n acks are seen, checking address stability during waits,
  // then drops en so the stage drains to IDLE after the last delivery.
  task automatic run_fetches(input int n, input int budget);
    int          acks;
    int          cyc;
    logic        pwait;
    logic [31:0] paddr;
    acks  = 0;
    cyc   = 0;
    pwait = 1'b0;
    paddr = 32'h0;
    while (acks < n && cyc < budget) begin
      sample();
      if (pwait && bus.imem_req) check("addr_stable", bus.imem_addr, paddr);
      pwait = bus.imem_req && !bus.imem_ack;
      paddr = bus.imem_addr;
      if (bus.imem_req && bus.imem_ack) begin
        ack_addrs.push_back(bus.imem_addr);
        acks++;
      end
      cyc++;
    end
    if (acks < n) timeout("run_fetches");
    drive_edge();
    en = 1'b0;
    cyc = 0;
    do begin
      sample();
      cyc++;
    end while ((bus.inst_valid || bus.imem_req) && cyc < 20);
    if (bus.inst_valid || bus.imem_req) timeout("drain");
  endtask

  task automatic check_addrs(input string name, input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] a2, input logic [31:0] a3, input int n);
    logic [31:0] exp_a[4];
    exp_a[0] = a0; exp_a[1] = a1; exp_a[2] = a2; exp_a[3] = a3;
    check({name, "_n"}, ack_addrs.size(), n);
    for (int i = 0; i < n && i < ack_addrs.size(); i++) check(name, ack_addrs[i], exp_a[i]);
  endtask

  initial begin
    int cyc;

    vecs[0] = '{target: 32'h0000_0100, exp_addr: 32'h0000_0100, exp_align: 1'b0};
    vecs[1] = '{target: 32'hFFFF_FFFC, exp_addr: 32'hFFFF_FFFC, exp_align: 1'b0};
    vecs[2] = '{target: 32'h0000_0042, exp_addr: 32'h0000_0040, exp_align: 1'b1};
    vecs[3] = '{target: 32'h0000_0080, exp_addr: 32'h0000_0080, exp_align: 1'b1};
    vecs[4] = '{target: 32'h0000_0007, exp_addr: 32'h0000_0004, exp_align: 1'b1};

    rst = 1'b1; en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    bus.inst_ready = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    sample();
    check("rst_req", bus.imem_req, 0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_inst_pc", bus.inst_pc, 32'h0);
    check("rst_valid", bus.inst_valid, 0);
    check("rst_align", align_err, 0);
    check("rst_count", fetch_count, 32'h0);

    // Zero-wait first fetch: valid two edges after reset release
    mem_on = 1'b1; mem_delay = 0;
    drive_edge();
    rst = 1'b0; en = 1'b1;
    sample();
    check("t1_idle_req", bus.imem_req, 0);
    sample();
    check("t1_req", bus.imem_req, 1);
    check("t1_req_addr", bus.imem_addr, 32'h0);
    check("t1_not_valid", bus.inst_valid, 0);
    bus.inst_ready = 1'b0;
    sample();
    check("t1_valid", bus.inst_valid, 1);
    check("t1_inst", bus.inst, 32'h2008_0005);
    check("t1_inst_pc", bus.inst_pc, 32'h0);
    check("t1_next_addr", bus.imem_addr, 32'h4);

    // Stall in HOLD for 5 cycles
    for (int i = 0; i < 5; i++) begin
      sample();
      check("stall_inst", bus.inst, 32'h2008_0005);
      check("stall_pc", bus.inst_pc, 32'h0);
      check("stall_req", bus.imem_req, 0);
      check("stall_count", fetch_count, 32'h0);
    end
    push_exp(32'h0);
    drive_edge();
    bus.inst_ready = 1'b1; en = 1'b0;
    drive_edge();
    bus.inst_ready = 1'b0;
    sample();
    check("stall_count_after", fetch_count, 32'h1);
    check("stall_idle_valid", bus.inst_valid, 0);
    check("stall_idle_req", bus.imem_req, 0);

    // 3-cycle memory, four back-to-back fetches
    do_reset();
    mem_delay = 3; bus.inst_ready = 1'b1; en = 1'b1;
    ack_addrs.delete();
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    run_fetches(4, 200);
    check_addrs("seq_addr", 32'h0, 32'h4, 32'h8, 32'hC, 4);
    check("seq_count", fetch_count, 32'h4);

    // Redirect while REQ waits on addr 8
    do_reset();
    mem_delay = 3; bus.inst_ready = 1'b1; en = 1'b1;
    push_exp(32'h0);
    push_exp(32'h4);
    cyc = 0;
    do begin
      sample();
      cyc++;
    end while (!(bus.imem_req && bus.imem_addr == 32'h8) && cyc < 100);
    if (cyc >= 100) timeout("wait_addr8");
    drive_edge();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    drive_edge();
    redirect = 1'b0;
    cyc = 0;
    do begin
      sample();
      check("pend_req", bus.imem_req, 1);
      check("pend_addr", bus.imem_addr, 32'h8);
      check("pend_valid", bus.inst_valid, 0);
      cyc++;
    end while (!bus.imem_ack && cyc < 20);
    if (!bus.imem_ack) timeout("pend_ack");
    sample();
    check("redir_req", bus.imem_req, 1);
    check("redir_addr", bus.imem_addr, 32'h100);
    check("redir_dropped", bus.inst_valid, 0);
    push_exp(32'h100);
    run_fetches(1, 100);
    check("redir_count", fetch_count, 32'h3);

    // Redirect in HOLD together with ready, then misaligned redirect
    do_reset();
    mem_delay = 0; bus.inst_ready = 1'b0; en = 1'b1;
    cyc = 0;
    do begin
      sample();
      cyc++;
    end while (!bus.inst_valid && cyc < 20);
    if (!bus.inst_valid) timeout("hold_wait");
    push_exp(32'h0);
    drive_edge();
    bus.inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0040;
    drive_edge();
    bus.inst_ready = 1'b0; redirect = 1'b0;
    sample();
    check("hr_count", fetch_count, 32'h1);
    check("hr_req", bus.imem_req, 1);
    check("hr_addr", bus.imem_addr, 32'h40);
    check("hr_valid", bus.inst_valid, 0);
    check("hr_align", align_err, 0);
    drive_edge();
    redirect = 1'b1; redirect_pc = 32'h0000_0042;
    sample();
    check("mis_hold_valid", bus.inst_valid, 1);
    check("mis_hold_pc", bus.inst_pc, 32'h40);
    drive_edge();
    redirect = 1'b0; en = 1'b0;
    sample();
    check("mis_align", align_err, 1);
    check("mis_req", bus.imem_req, 1);
    check("mis_addr", bus.imem_addr, 32'h40);
    check("mis_valid", bus.inst_valid, 0);
    check("mis_count", fetch_count, 32'h1);

    // Reset during REQ, then a late ack in IDLE
    mem_on = 1'b0;
    do_reset();
    en = 1'b1;
    sample();
    sample();
    check("rr_req", bus.imem_req, 1);
    drive_edge();
    rst = 1'b1;
    drive_edge();
    rst = 1'b0; en = 1'b0; late_ack = 1'b1;
    sample();
    check("rr_req_drop", bus.imem_req, 0);
    check("rr_addr", bus.imem_addr, 32'h0);
    drive_edge();
    late_ack = 1'b0;
    sample();
    check("rr_req2", bus.imem_req, 0);
    check("rr_addr2", bus.imem_addr, 32'h0);
    check("rr_inst", bus.inst, 32'h0);
    check("rr_inst_pc", bus.inst_pc, 32'h0);
    check("rr_valid", bus.inst_valid, 0);
    check("rr_align", align_err, 0);
    check("rr_count", fetch_count, 32'h0);

    // Table: redirects while IDLE
    for (int i = 0; i < 5; i++) begin
      drive_edge();
      redirect = 1'b1; redirect_pc = vecs[i].target;
      drive_edge();
      redirect = 1'b0;
      sample();
      check("tbl_addr", bus.imem_addr, vecs[i].exp_addr);
      check("tbl_req", bus.imem_req, 0);
      check("tbl_align", align_err, 32'(vecs[i].exp_align));
    end

    // PC wrap from FFFF_FFFC to 0
    drive_edge();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    drive_edge();
    redirect = 1'b0; mem_on = 1'b1; mem_delay = 0; bus.inst_ready = 1'b1; en = 1'b1;
    ack_addrs.delete();
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0);
    run_fetches(2, 100);
    check_addrs("wrap_addr", 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 2);
    check("wrap_count", fetch_count, 32'h2);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage of the single-issue MIPS-subset CPU; sits directly upstream of the instruction decoder.
- Owns the PC and issues word reads to instruction memory over a req/ack handshake.
- Latches the returned word into an instruction register and presents it to the decoder with a valid/ready handshake.
- Accepts PC redirects for branch/jump from the execute stage and discards any in-flight fetch on redirect.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  run enable; when low, no new fetch is started.
imem_req  out  1  instruction memory read request.
imem_addr  out  32  byte address of requested word.
imem_ack  in  1  memory response strobe; imem_rdata is valid in the same cycle.
imem_rdata  in  32  instruction word returned by memory.
redirect  in  1  one-cycle pulse: load new PC from redirect_pc.
redirect_pc  in  32  branch/jump target.
inst  out  32  instruction register, fed to the decoder input.
inst_pc  out  32  address of the word currently held in inst.
inst_valid  out  1  inst/inst_pc hold an undelivered instruction.
inst_ready  in  1  decoder accepts inst this cycle.
align_err  out  1  sticky flag: a misaligned redirect_pc was received.
fetch_count  out  32  number of instructions delivered (valid&&ready).

Behaviour:
- Reset (clk edge with rst=1) overrides everything:
  - pc=PC_RESET, state=IDLE.
  - imem_req=0, imem_addr=PC_RESET.
  - inst=0, inst_pc=0, inst_valid=0.
  - align_err=0, fetch_count=0, redirect-pending flag=0.
  - Reset mid-request drops imem_req on the next edge. An ack arriving in IDLE is ignored.
- imem_addr always equals pc. Bits [1:0] are always 0.
- State IDLE:
  - imem_req=0, inst_valid=0.
  - If en=1, go to REQ next cycle.
- State REQ:
  - imem_req=1. imem_addr is held stable until imem_ack.
  - On imem_ack with no pending redirect: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4, go to HOLD.
  - Latency: ack in cycle N gives inst_valid=1 in cycle N+1.
- State HOLD:
  - inst_valid=1. inst and inst_pc are held stable until inst_ready=1.
  - On valid&&ready: fetch_count<=fetch_count+1 (wraps mod 2^32). Go to REQ if en=1, else IDLE.
  - With a zero-wait memory this gives one instruction per 2 cycles.
- Redirect, applied per state:
  - pc is loaded from {redirect_pc[31:2],2'b00}.
  - If redirect_pc[1:0]!=0, align_err<=1 and stays set until reset.
  - IDLE: pc loaded; state unchanged.
  - REQ without ack in the same cycle: set the pending flag and store the target. Keep imem_req asserted until ack, because the memory handshake cannot be aborted. On that ack, discard imem_rdata, load pc from the stored target, clear pending, and go to REQ (IDLE if en=0). No inst_valid is produced.
  - REQ with ack in the same cycle: discard imem_rdata, load pc from redirect_pc, go to REQ or IDLE.
  - A second redirect while pending overwrites the stored target; the last redirect wins.
  - HOLD: inst_valid<=0 next cycle, pc loaded, go to REQ or IDLE.
  - HOLD with redirect and inst_ready in the same cycle: the held instruction counts as delivered (fetch_count increments), and the redirect target is used as the next pc.
- en=0 never aborts a started REQ or HOLD. It only prevents starting a new fetch.
- pc+4 wraps from 32'hFFFF_FFFC to 32'h0000_0000.
- Outputs are registered except imem_req and imem_addr, which are decoded from state and pc.

Test Plan:
- Reset, then en=1, memory acks in the same cycle as req with 0x20080005 at addr 0 → inst_valid rises 2 cycles after reset release; inst=0x20080005, inst_pc=0, next imem_addr=4.
- Memory with 3-cycle ack delay, inst_ready held 1, 4 fetches → imem_addr held stable during each wait; sequence 0,4,8,C; fetch_count=4.
- inst_ready=0 for 5 cycles in HOLD → inst/inst_pc unchanged, imem_req=0, no count change; ready=1 → count+1.
- Redirect to 0x100 while REQ is waiting on addr 8 → req stays up until ack; that data is dropped with no inst_valid; next imem_addr=0x100 and first delivered inst_pc=0x100.
- Redirect to 0x40 in HOLD together with inst_ready=1 → fetch_count+1; next request at 0x40. Redirect to 0x42 → align_err=1, request at 0x40.
- rst asserted during REQ → next cycle imem_req=0, pc=PC_RESET; a late ack is ignored; all outputs are at their reset values.
